// File: rtl/dma_sector_pkg.sv
// rtl/dma_sector_pkg.sv - shared states, sizes and helpers for the DMA sector slave
package dma_sector_pkg;

    localparam int         WORDS            = 128;
    localparam logic [6:0] LAST_WORD        = 7'd127;
    localparam int         READ_LATENCY_MIN = 1;
    localparam int         READ_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        AV_READ  = 2'd1,
        AV_WRITE = 2'd2,
        CORE     = 2'd3
    } state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dma_sector_slave_if.sv
// rtl/dma_sector_slave_if.sv - Avalon-MM slave port, local byte port and sector done strobes
interface dma_sector_slave_if;

    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        core_req;
    logic        core_we;
    logic [8:0]  core_addr;
    logic [7:0]  core_wdata;
    logic [7:0]  core_rdata;
    logic        core_ack;
    logic        sector_wr_done;
    logic        sector_rd_done;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        input  core_req, core_we, core_addr, core_wdata,
        output mem_waitrequest, mem_readdata, mem_readdatavalid,
        output core_rdata, core_ack, sector_wr_done, sector_rd_done
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        output core_req, core_we, core_addr, core_wdata,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid,
        input  core_rdata, core_ack, sector_wr_done, sector_rd_done
    );

endinterface

// File: rtl/sector_ram.sv
// rtl/sector_ram.sv - single-port 128x32 buffer, byte-lane write, registered read
module sector_ram
    import dma_sector_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [6:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    // Contents and read register are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dma_sector_slave.sv
// rtl/dma_sector_slave.sv - 512-byte sector buffer shared by an Avalon-MM slave and a local byte port
module dma_sector_slave
    import dma_sector_pkg::*;
#(
    parameter int READ_LATENCY = 2
)(
    input  logic              clk_sys,
    input  logic              reset,
    dma_sector_slave_if.slave bus
);

    localparam int LAT = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                         (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [6:0]  rd_idx_q, rd_idx_d;
    logic        waitreq_q, waitreq_d;
    logic        rdv_q, rdv_d;
    logic [31:0] readdata_q, readdata_d;
    logic        core_ack_q, core_ack_d;
    logic [7:0]  core_rdata_q, core_rdata_d;
    logic        wr_done_q, wr_done_d;
    logic        rd_done_q, rd_done_d;

    logic        ram_en;
    logic [3:0]  ram_we;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [6:0]  av_idx;
    logic        unused_addr_bits;

    assign av_idx           = bus.mem_address[8:2];
    assign unused_addr_bits = ^{bus.mem_address[31:9], bus.mem_address[1:0]};

    sector_ram u_ram (
        .clk   (clk_sys),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_idx_d     = rd_idx_q;
        rdv_d        = 1'b0;
        readdata_d   = readdata_q;
        core_ack_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        wr_done_d    = 1'b0;
        rd_done_d    = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 4'b0000;
        ram_addr     = av_idx;
        ram_wdata    = bus.mem_writedata;

        case (state_q)
            IDLE: begin
                // Avalon wins; a read beats a simultaneous write, which is dropped.
                if (!waitreq_q && bus.mem_read) begin
                    state_d  = AV_READ;
                    cnt_d    = CNT_INIT;
                    rd_idx_d = av_idx;
                    ram_en   = 1'b1;
                end else if (!waitreq_q && bus.mem_write) begin
                    state_d   = AV_WRITE;
                    ram_en    = 1'b1;
                    ram_we    = bus.mem_byteenable;
                    wr_done_d = (av_idx == LAST_WORD);
                end else if (!waitreq_q && bus.core_req && !core_ack_q) begin
                    // Prefetch the word so the byte is ready when CORE completes.
                    state_d  = CORE;
                    ram_en   = 1'b1;
                    ram_addr = bus.core_addr[8:2];
                end
            end
            AV_READ: begin
                if (cnt_q == 2'd0) begin
                    state_d    = IDLE;
                    rdv_d      = 1'b1;
                    readdata_d = ram_rdata;
                    rd_done_d  = (rd_idx_q == LAST_WORD);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            AV_WRITE: begin
                state_d = IDLE;
            end
            CORE: begin
                state_d    = IDLE;
                core_ack_d = 1'b1;
                ram_addr   = bus.core_addr[8:2];
                if (bus.core_we) begin
                    ram_en    = 1'b1;
                    ram_we    = lane_mask(bus.core_addr[1:0]);
                    ram_wdata = {4{bus.core_wdata}};
                end else begin
                    case (bus.core_addr[1:0])
                        2'd0:    core_rdata_d = ram_rdata[7:0];
                        2'd1:    core_rdata_d = ram_rdata[15:8];
                        2'd2:    core_rdata_d = ram_rdata[23:16];
                        default: core_rdata_d = ram_rdata[31:24];
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        waitreq_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            rd_idx_q     <= 7'd0;
            waitreq_q    <= 1'b1;
            rdv_q        <= 1'b0;
            readdata_q   <= 32'd0;
            core_ack_q   <= 1'b0;
            core_rdata_q <= 8'd0;
            wr_done_q    <= 1'b0;
            rd_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_idx_q     <= rd_idx_d;
            waitreq_q    <= waitreq_d;
            rdv_q        <= rdv_d;
            readdata_q   <= readdata_d;
            core_ack_q   <= core_ack_d;
            core_rdata_q <= core_rdata_d;
            wr_done_q    <= wr_done_d;
            rd_done_q    <= rd_done_d;
        end
    end

    assign bus.mem_waitrequest   = waitreq_q;
    assign bus.mem_readdata      = readdata_q;
    assign bus.mem_readdatavalid = rdv_q;
    assign bus.core_rdata        = core_rdata_q;
    assign bus.core_ack          = core_ack_q;
    assign bus.sector_wr_done    = wr_done_q;
    assign bus.sector_rd_done    = rd_done_q;

endmodule

// File: tb/tb_dma_sector_slave.sv
// tb/tb_dma_sector_slave.sv - directed bench for dma_sector_slave at read latencies 2 and 4
module tb_dma_sector_slave;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    dma_sector_slave_if bus();
    dma_sector_slave_if bus4();

    always #5 clk_sys = ~clk_sys;

    assign bus4.mem_address    = bus.mem_address;
    assign bus4.mem_read       = bus.mem_read;
    assign bus4.mem_write      = bus.mem_write;
    assign bus4.mem_writedata  = bus.mem_writedata;
    assign bus4.mem_byteenable = bus.mem_byteenable;
    assign bus4.core_req       = bus.core_req;
    assign bus4.core_we        = bus.core_we;
    assign bus4.core_addr      = bus.core_addr;
    assign bus4.core_wdata     = bus.core_wdata;

    dma_sector_slave #(.READ_LATENCY(2)) u_dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus.slave)
    );

    dma_sector_slave #(.READ_LATENCY(4)) u_dut4 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus4.slave)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic av_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output logic wd);
        bit ok = 0;
        bus.mem_address = a; bus.mem_writedata = d; bus.mem_byteenable = be; bus.mem_write = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = !bus.mem_waitrequest && !bus4.mem_waitrequest;
            tick();
        end
        bus.mem_write = 1'b0;
        wd = bus.sector_wr_done;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL write_accept: got timeout want accepted"); end
    endtask

    task automatic av_read(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d4,
                           output int l1, output int l4, output int n1,
                           output logic w1, output logic rd1, output logic rd4);
        bit ok = 0;
        d1 = 0; d4 = 0; l1 = -1; l4 = -1; n1 = 0; w1 = 1'b1; rd1 = 1'b0; rd4 = 1'b0;
        bus.mem_address = a; bus.mem_read = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = !bus.mem_waitrequest && !bus4.mem_waitrequest;
            tick();
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.mem_readdatavalid) begin
                n1++;
                if (l1 < 0) begin
                    l1 = c; d1 = bus.mem_readdata; w1 = bus.mem_waitrequest; rd1 = bus.sector_rd_done;
                end
            end
            if (bus4.mem_readdatavalid && l4 < 0) begin
                l4 = c; d4 = bus4.mem_readdata; rd4 = bus4.sector_rd_done;
            end
        end
    endtask

    task automatic core_access(input logic we, input logic [8:0] a, input logic [7:0] wd,
                               output logic [7:0] rd, output int ack_c);
        ack_c = -1; rd = 8'h00;
        bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = wd;
        for (int c = 1; c <= 10 && ack_c < 0; c++) begin
            tick();
            if (bus.core_ack) begin ack_c = c; rd = bus.core_rdata; bus.core_req = 1'b0; end
        end
        bus.core_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_address = 0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_writedata = 0;
        bus.mem_byteenable = 0; bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({bus.mem_waitrequest, bus4.mem_waitrequest} !== 2'b11) begin
            miscompares++; $display("FAIL reset_waitreq: got %b want 11", {bus.mem_waitrequest, bus4.mem_waitrequest});
        end
        vectors++;
        if ({bus.mem_readdatavalid, bus.core_ack, bus.sector_wr_done, bus.sector_rd_done} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_strobes: got %b want 0000",
                {bus.mem_readdatavalid, bus.core_ack, bus.sector_wr_done, bus.sector_rd_done});
        end
        vectors++;
        if ({bus.mem_readdata, bus.core_rdata} !== 40'd0) begin
            miscompares++; $display("FAIL reset_data: got %h want 0", {bus.mem_readdata, bus.core_rdata});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.mem_waitrequest !== 1'b1) begin
            miscompares++; $display("FAIL release_waitreq_hold: got %b want 1", bus.mem_waitrequest);
        end
        tick();
        vectors++;
        if ({bus.mem_waitrequest, bus4.mem_waitrequest} !== 2'b00) begin
            miscompares++; $display("FAIL release_waitreq_fall: got %b want 00", {bus.mem_waitrequest, bus4.mem_waitrequest});
        end
    endtask

    task automatic test_write_read();
        logic wd, w1, rd1, rd4;
        logic [31:0] d1, d4;
        int l1, l4, n1;
        av_write(32'h10, 32'hDEADBEEF, 4'b1111, wd);
        vectors++;
        if (wd !== 1'b0) begin miscompares++; $display("FAIL wr_done_not_127: got %b want 0", wd); end
        av_read(32'h10, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (l1 !== 2 || d1 !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL read_l2: got lat %0d data %h want lat 2 data deadbeef", l1, d1);
        end
        vectors++;
        if (w1 !== 1'b0 || rd1 !== 1'b0 || n1 !== 1) begin
            miscompares++; $display("FAIL read_l2_flags: got wr %b rd_done %b pulses %0d want 0 0 1", w1, rd1, n1);
        end
        vectors++;
        if (l4 !== 4 || d4 !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL read_l4: got lat %0d data %h want lat 4 data deadbeef", l4, d4);
        end
        vectors++;
        if (bus.mem_readdatavalid !== 1'b0 || bus.mem_readdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL readdata_hold: got rdv %b data %h want 0 deadbeef",
                bus.mem_readdatavalid, bus.mem_readdata);
        end
    endtask

    task automatic test_byte_enable();
        logic wd, w1, rd1, rd4;
        logic [31:0] d1, d4;
        int l1, l4, n1;
        av_write(32'h20, 32'h0, 4'b1111, wd);
        av_write(32'h20, 32'h11223344, 4'b0101, wd);
        av_read(32'h20, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (d1 !== 32'h00220044 || d4 !== 32'h00220044) begin
            miscompares++; $display("FAIL byte_enable: got %h/%h want 00220044", d1, d4);
        end
    endtask

    task automatic test_rw_collision();
        logic w1, rd1, rd4;
        logic [31:0] d1, d4;
        int l1, l4, n1;
        bus.mem_writedata = 32'h0; bus.mem_byteenable = 4'b1111; bus.mem_write = 1'b1;
        av_read(32'h10, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (d1 !== 32'hDEADBEEF || l1 !== 2) begin
            miscompares++; $display("FAIL rw_as_read: got lat %0d data %h want 2 deadbeef", l1, d1);
        end
        av_read(32'h10, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (d1 !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL rw_write_dropped: got %h want deadbeef", d1);
        end
    endtask

    task automatic test_alias_wr_done();
        logic wd, w1, rd1, rd4;
        logic [31:0] d1, d4;
        int l1, l4, n1;
        av_write(32'h3FC, 32'hCAFEF00D, 4'b1111, wd);
        vectors++;
        if (wd !== 1'b1) begin miscompares++; $display("FAIL wr_done_pulse: got %b want 1", wd); end
        tick();
        vectors++;
        if (bus.sector_wr_done !== 1'b0) begin miscompares++; $display("FAIL wr_done_once: got %b want 0", bus.sector_wr_done); end
        av_read(32'h1FC, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (d1 !== 32'hCAFEF00D || l1 !== 2) begin
            miscompares++; $display("FAIL alias_read: got lat %0d data %h want 2 cafef00d", l1, d1);
        end
        vectors++;
        if (rd1 !== 1'b1 || rd4 !== 1'b1) begin
            miscompares++; $display("FAIL rd_done_with_rdv: got %b%b want 11", rd1, rd4);
        end
    endtask

    task automatic test_core_write();
        logic w1, rd1, rd4;
        logic [31:0] d1, d4;
        logic [7:0] cr;
        int l1, l4, n1, ack_c;
        core_access(1'b1, 9'h1FF, 8'hAB, cr, ack_c);
        vectors++;
        if (ack_c !== 2) begin miscompares++; $display("FAIL core_write_ack: got cycle %0d want 2", ack_c); end
        tick();
        vectors++;
        if (bus.core_ack !== 1'b0) begin miscompares++; $display("FAIL core_ack_once: got %b want 0", bus.core_ack); end
        core_access(1'b0, 9'h1FE, 8'h00, cr, ack_c);
        vectors++;
        if (cr !== 8'hFE || ack_c !== 2) begin
            miscompares++; $display("FAIL core_read: got %h at cycle %0d want fe at 2", cr, ack_c);
        end
        av_read(32'h1FC, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (d1 !== 32'hABFEF00D || rd1 !== 1'b1) begin
            miscompares++; $display("FAIL core_write_lane: got %h rd_done %b want abfef00d 1", d1, rd1);
        end
    endtask

    task automatic test_arbitration();
        int rdv_c = -1, ack_c = -1;
        logic [7:0] cr = 8'h00;
        logic [31:0] rdat = 32'h0;
        bus.mem_address = 32'h10; bus.mem_read = 1'b1;
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h012;
        tick();
        bus.mem_read = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.mem_readdatavalid && rdv_c < 0) begin rdv_c = c; rdat = bus.mem_readdata; end
            if (bus.core_ack && ack_c < 0) begin ack_c = c; cr = bus.core_rdata; bus.core_req = 1'b0; end
        end
        bus.core_req = 1'b0;
        vectors++;
        if (rdv_c !== 2 || rdat !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL arb_read_first: got cycle %0d data %h want 2 deadbeef", rdv_c, rdat);
        end
        vectors++;
        if (ack_c !== 4 || cr !== 8'hAD) begin
            miscompares++; $display("FAIL arb_core_after: got cycle %0d byte %h want 4 ad", ack_c, cr);
        end
    endtask

    task automatic test_back_to_back();
        int acc2 = -1, r1 = -1, r2 = -1, n = 0;
        logic [31:0] q1 = 0, q2 = 0;
        bus.mem_address = 32'h10; bus.mem_read = 1'b1;
        tick();
        bus.mem_address = 32'h20;
        for (int c = 1; c <= 8; c++) begin
            if (acc2 < 0 && bus.mem_read && !bus.mem_waitrequest) acc2 = c;
            tick();
            if (acc2 == c) bus.mem_read = 1'b0;
            if (bus.mem_readdatavalid) begin
                n++;
                if (r1 < 0) begin r1 = c; q1 = bus.mem_readdata; end
                else if (r2 < 0) begin r2 = c; q2 = bus.mem_readdata; end
            end
        end
        bus.mem_read = 1'b0;
        vectors++;
        if (r1 !== 2 || q1 !== 32'hDEADBEEF || acc2 !== 3) begin
            miscompares++; $display("FAIL b2b_first: got rdv %0d data %h accept2 %0d want 2 deadbeef 3", r1, q1, acc2);
        end
        vectors++;
        if (r2 !== 5 || q2 !== 32'h00220044 || n !== 2) begin
            miscompares++; $display("FAIL b2b_second: got rdv %0d data %h pulses %0d want 5 00220044 2", r2, q2, n);
        end
    endtask

    task automatic test_reset_during_read();
        logic wd, w1, rd1, rd4;
        logic [31:0] d1, d4;
        int l1, l4, n1, stray = 0;
        av_write(32'h40, 32'h5A5A1234, 4'b1111, wd);
        bus.mem_address = 32'h40; bus.mem_read = 1'b1;
        tick();
        bus.mem_read = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.mem_waitrequest, bus4.mem_waitrequest, bus.mem_readdata} !== {2'b11, 32'h0}) begin
            miscompares++; $display("FAIL rst_mid_read: got wr %b%b data %h want 11 0",
                bus.mem_waitrequest, bus4.mem_waitrequest, bus.mem_readdata);
        end
        repeat (3) begin
            tick();
            if (bus.mem_readdatavalid || bus4.mem_readdatavalid) stray++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus4.mem_waitrequest !== 1'b1) begin
            miscompares++; $display("FAIL rst_release_hold: got %b want 1", bus4.mem_waitrequest);
        end
        tick();
        vectors++;
        if ({bus.mem_waitrequest, bus4.mem_waitrequest} !== 2'b00) begin
            miscompares++; $display("FAIL rst_release_fall: got %b want 00", {bus.mem_waitrequest, bus4.mem_waitrequest});
        end
        repeat (8) begin
            tick();
            if (bus.mem_readdatavalid || bus4.mem_readdatavalid) stray++;
        end
        vectors++;
        if (stray !== 0) begin miscompares++; $display("FAIL rst_cancel: got %0d strobes want 0", stray); end
        av_read(32'h40, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (d4 !== 32'h5A5A1234 || l4 !== 4 || d1 !== 32'h5A5A1234) begin
            miscompares++; $display("FAIL rst_buffer_kept: got %h/%h lat %0d want 5a5a1234 lat 4", d1, d4, l4);
        end
        av_read(32'h10, d1, d4, l1, l4, n1, w1, rd1, rd4);
        vectors++;
        if (d1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rst_buffer_kept2: got %h want deadbeef", d1); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_rw_collision();
        test_alias_wr_done();
        test_core_write();
        test_arbitration();
        test_back_to_back();
        test_reset_during_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
